rst_stream_ctrl: RTL

Sequencing controller placed in front of rst_cipher (the 1-cycle-latency encryption core).
- Runs the key-install check.
- Accepts a plaintext byte stream through a valid/ready handshake and issues one character at a time to the core.
- Captures each ciphertext pair into a one-entry output buffer with valid/ready backpressure.
- Drops invalid characters and counts them, and tracks message boundaries.

---
 rtl/rst_stream_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rst_stream_ctrl.sv
// Sequencer between a byte stream and the rst_cipher core.
// Define RST_STREAM_CTRL_PREFILTER_EN to drop non-alnum bytes early.
module rst_stream_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [95:0]      key_in,
  input  logic             key_load,
  output logic             key_ack,
  output logic             key_err,
  output logic             key_ok,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [15:0]      out_ctxt,
  output logic             out_last,
  input  logic             out_ready,
  output logic             msg_done,
  output logic             char_drop,
  output logic [CNT_W-1:0] char_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [95:0]      c_key,
  output logic             c_ptxt_valid,
  output logic [7:0]       c_ptxt_char,
  input  logic [15:0]      c_ctxt_str,
  input  logic             c_ctxt_ready,
  input  logic             c_err_invalid_key,
  input  logic             c_err_invalid_ptxt_char,
  input  logic             c_key_not_installed
);

  typedef enum logic [2:0] {
    S_NO_KEY,
    S_KEY_CHK,
    S_READY,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t      state;
  logic [95:0] key_reg;
  logic [7:0]  char_reg;
  logic        last_reg;
  logic        hs;
  logic        unused_ptxt_err;

  // Drop decision in WAIT is "not ready and key still installed".
  assign unused_ptxt_err = c_err_invalid_ptxt_char;

  assign c_key        = key_reg;
  assign in_ready     = (state == S_READY) && !out_valid && !key_load;
  assign hs           = in_valid && in_ready;
  assign c_ptxt_valid = (state == S_ISSUE);
  assign c_ptxt_char  = c_ptxt_valid ? char_reg : 8'h00;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef RST_STREAM_CTRL_PREFILTER_EN
  function automatic logic is_alnum(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) ||
           (c >= 8'h41 && c <= 8'h5A) ||
           (c >= 8'h61 && c <= 8'h7A);
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_NO_KEY;
      key_reg   <= '0;
      char_reg  <= '0;
      last_reg  <= 1'b0;
      key_ack   <= 1'b0;
      key_err   <= 1'b0;
      key_ok    <= 1'b0;
      out_valid <= 1'b0;
      out_ctxt  <= '0;
      out_last  <= 1'b0;
      msg_done  <= 1'b0;
      char_drop <= 1'b0;
      char_cnt  <= '0;
      drop_cnt  <= '0;
    end else begin
      key_ack   <= 1'b0;
      key_err   <= 1'b0;
      msg_done  <= 1'b0;
      char_drop <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      unique case (state)
        S_NO_KEY: begin
          if (key_load) begin
            key_reg <= key_in;
            state   <= S_KEY_CHK;
          end
        end
        S_KEY_CHK: begin
          if (c_err_invalid_key) begin
            key_err <= 1'b1;
            key_ok  <= 1'b0;
            state   <= S_NO_KEY;
          end else begin
            key_ack  <= 1'b1;
            key_ok   <= 1'b1;
            char_cnt <= '0;
            drop_cnt <= '0;
            state    <= S_READY;
          end
        end
        S_READY: begin
          if (key_load && !out_valid) begin
            key_reg <= key_in;
            state   <= S_KEY_CHK;
          end else if (hs) begin
            char_reg <= in_char;
            last_reg <= in_last;
`ifdef RST_STREAM_CTRL_PREFILTER_EN
            if (!is_alnum(in_char)) begin
              char_drop <= 1'b1;
              drop_cnt  <= sat_inc(drop_cnt);
              msg_done  <= in_last;
            end else begin
              state <= S_ISSUE;
            end
`else
            state <= S_ISSUE;
`endif
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          state    <= S_READY;
          msg_done <= last_reg;
          if (c_ctxt_ready) begin
            out_ctxt  <= c_ctxt_str;
            out_valid <= 1'b1;
            out_last  <= last_reg;
            char_cnt  <= sat_inc(char_cnt);
          end else if (c_key_not_installed) begin
            key_err <= 1'b1;
            key_ok  <= 1'b0;
            state   <= S_NO_KEY;
          end else begin
            char_drop <= 1'b1;
            drop_cnt  <= sat_inc(drop_cnt);
          end
        end
        default: state <= S_NO_KEY;
      endcase
    end
  end

endmodule
